// File: rtl/decrypt_data_buffer.sv
// Word FIFO that feeds a byte-wide decryptor: stores DATA_W-bit words and
// serialises the head word one byte lane at a time under a ready handshake.
module decrypt_data_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     read_ready_i,
    input  logic [DATA_W-1:0]        rc4_data_i,
    input  logic                     flush_i,
    input  logic                     byte_ready_i,
    output logic [7:0]               byte_o,
    output logic                     byte_valid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int LANES = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_lane;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_xfer;
    logic              w_last_lane;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic [7:0]        w_byte;

    // Status flags come from the registered count only, never from the strobes.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = read_ready_i && !w_full && !flush_i;
    assign w_xfer      = !w_empty && byte_ready_i && !flush_i;
    assign w_last_lane = (r_lane == LW'(LANES - 1));
    assign w_pop       = w_xfer && w_last_lane;
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        // NOTE: default first so every path assigns w_byte and no latch is inferred.
        w_byte = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane == LW'(l)) begin
                w_byte = MSB_FIRST ? w_head[DATA_W-1-8*l -: 8] : w_head[8*l +: 8];
            end
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count make stale words unreachable.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_mem[r_wr_ptr] <= rc4_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lane     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_xfer) begin
                r_lane <= w_last_lane ? '0 : r_lane + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // A write into a full buffer is lost even if a pop frees a slot this cycle.
            if (read_ready_i && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign byte_o       = w_byte;
    assign byte_valid_o = !w_empty;
    assign full_o       = w_full;
    assign empty_o      = w_empty;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_decrypt_data_buffer.sv
// Directed bench for decrypt_data_buffer: one MSB-first and one LSB-first
// instance share the same stimulus; outputs are sampled on the falling edge.
module tb_decrypt_data_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        read_ready_i;
    logic [31:0] rc4_data_i;
    logic        flush_i;
    logic        byte_ready_i;

    logic [7:0]  byte_o,       byte1_o;
    logic        byte_valid_o, byte_valid1_o;
    logic        full_o,       full1_o;
    logic        empty_o,      empty1_o;
    logic [2:0]  count_o,      count1_o;
    logic        overflow_o,   overflow1_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decrypt_data_buffer #(.DATA_W(32), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .read_ready_i(read_ready_i), .rc4_data_i(rc4_data_i),
        .flush_i(flush_i), .byte_ready_i(byte_ready_i), .byte_o(byte_o),
        .byte_valid_o(byte_valid_o), .full_o(full_o), .empty_o(empty_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    decrypt_data_buffer #(.DATA_W(32), .DEPTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_i(clk), .rst_i(rst_i), .read_ready_i(read_ready_i), .rc4_data_i(rc4_data_i),
        .flush_i(flush_i), .byte_ready_i(byte_ready_i), .byte_o(byte1_o),
        .byte_valid_o(byte_valid1_o), .full_o(full1_o), .empty_o(empty1_o),
        .count_o(count1_o), .overflow_o(overflow1_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [31:0] words [5];
    logic [31:0] exp_word;
    int          pushed;
    int          idx;

    initial begin
        rst_i = 1'b1; read_ready_i = 1'b0; rc4_data_i = '0; flush_i = 1'b0; byte_ready_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        check("rst_empty",    32'(empty_o),      32'd1);
        check("rst_full",     32'(full_o),       32'd0);
        check("rst_valid",    32'(byte_valid_o), 32'd0);
        check("rst_overflow", 32'(overflow_o),   32'd0);
        check("rst_count",    32'(count_o),      32'd0);

        // Single word, MSB first, continuous ready.
        read_ready_i = 1'b1; rc4_data_i = 32'hA1B2C3D4; byte_ready_i = 1'b1;
        step();
        read_ready_i = 1'b0;
        check("msb_valid", 32'(byte_valid_o), 32'd1);
        check("msb_count", 32'(count_o), 32'd1);
        check("lsb_inst_b0", 32'(byte1_o), 32'hD4);
        check("msb_b0", 32'(byte_o), 32'hA1); step();
        check("msb_b1", 32'(byte_o), 32'hB2); step();
        check("msb_b2", 32'(byte_o), 32'hC3); step();
        check("msb_b3", 32'(byte_o), 32'hD4); step();
        check("msb_empty", 32'(empty_o), 32'd1);
        check("msb_valid_off", 32'(byte_valid_o), 32'd0);

        // LSB-first ordering.
        read_ready_i = 1'b1; rc4_data_i = 32'h11223344;
        step();
        read_ready_i = 1'b0;
        check("lsb_b0", 32'(byte1_o), 32'h44); step();
        check("lsb_b1", 32'(byte1_o), 32'h33); step();
        check("lsb_b2", 32'(byte1_o), 32'h22); step();
        check("lsb_b3", 32'(byte1_o), 32'h11); step();
        check("lsb_empty", 32'(empty1_o), 32'd1);

        // Fill past capacity with the consumer stalled.
        byte_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = 32'h01020304 + 32'(i) * 32'h10101010;
        for (int i = 0; i < 5; i++) begin
            read_ready_i = 1'b1; rc4_data_i = words[i];
            step();
            if (i == 3) begin
                check("fill_full4",  32'(full_o),     32'd1);
                check("fill_count4", 32'(count_o),    32'd4);
                check("fill_ovf4",   32'(overflow_o), 32'd0);
            end
        end
        read_ready_i = 1'b0;
        check("fill_ovf",   32'(overflow_o), 32'd1);
        check("fill_count", 32'(count_o),    32'd4);
        byte_ready_i = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int l = 0; l < 4; l++) begin
                exp_word = words[w];
                check($sformatf("drain_w%0d_l%0d", w, l), 32'(byte_o), 32'(exp_word[31-8*l -: 8]));
                step();
            end
        end
        check("drain_empty",  32'(empty_o),    32'd1);
        check("drain_ovf_sticky", 32'(overflow_o), 32'd1);
        byte_ready_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_clr_ovf", 32'(overflow_o), 32'd0);

        // Full with a push colliding with the last-lane pop.
        for (int i = 0; i < 4; i++) begin
            read_ready_i = 1'b1; rc4_data_i = words[i];
            step();
        end
        read_ready_i = 1'b0; byte_ready_i = 1'b1;
        step(); step(); step();
        exp_word = words[0];
        check("fd_lane3", 32'(byte_o), 32'(exp_word[7:0]));
        read_ready_i = 1'b1; rc4_data_i = 32'hDEADBEEF;
        step();
        read_ready_i = 1'b0; byte_ready_i = 1'b0;
        check("fd_count", 32'(count_o),    32'd3);
        check("fd_ovf",   32'(overflow_o), 32'd1);
        check("fd_full",  32'(full_o),     32'd0);
        exp_word = words[1];
        check("fd_next_head", 32'(byte_o), 32'(exp_word[31:24]));
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Stream ten words through the wrapping pointers with random backpressure.
        pushed = 0; idx = 0;
        for (int cyc = 0; cyc < 400 && idx < 40; cyc++) begin
            byte_ready_i = 1'($urandom_range(0, 1));
            if (byte_ready_i && byte_valid_o) begin
                exp_word = 32'(idx / 4);
                check($sformatf("wrap_byte%0d", idx), 32'(byte_o), 32'(exp_word[31-8*(idx%4) -: 8]));
                idx++;
            end
            if (pushed < 10 && !full_o) begin
                read_ready_i = 1'b1; rc4_data_i = 32'(pushed); pushed++;
            end else begin
                read_ready_i = 1'b0;
            end
            step();
        end
        read_ready_i = 1'b0; byte_ready_i = 1'b0;
        check("wrap_bytes_seen", 32'(idx), 32'd40);
        check("wrap_empty", 32'(empty_o), 32'd1);
        check("wrap_no_ovf", 32'(overflow_o), 32'd0);

        // Flush on lane 2 with a concurrent write.
        for (int i = 0; i < 3; i++) begin
            read_ready_i = 1'b1; rc4_data_i = words[i];
            step();
        end
        read_ready_i = 1'b0; byte_ready_i = 1'b1;
        step(); step();
        exp_word = words[0];
        check("fl_lane2", 32'(byte_o), 32'(exp_word[15:8]));
        flush_i = 1'b1; read_ready_i = 1'b1; rc4_data_i = 32'h99999999;
        step();
        flush_i = 1'b0; read_ready_i = 1'b0; byte_ready_i = 1'b0;
        check("fl_count", 32'(count_o),    32'd0);
        check("fl_empty", 32'(empty_o),    32'd1);
        check("fl_ovf",   32'(overflow_o), 32'd0);
        read_ready_i = 1'b1; rc4_data_i = 32'hCAFEF00D;
        step();
        read_ready_i = 1'b0;
        check("fl_next_lane0", 32'(byte_o), 32'hCA);
        check("fl_next_count", 32'(count_o), 32'd1);

        // Reset in the middle of a word discards it.
        byte_ready_i = 1'b1;
        step();
        byte_ready_i = 1'b0; rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mr_empty", 32'(empty_o),      32'd1);
        check("mr_valid", 32'(byte_valid_o), 32'd0);
        read_ready_i = 1'b1; rc4_data_i = 32'h5A6B7C8D;
        step();
        read_ready_i = 1'b0;
        check("mr_lane0", 32'(byte_o), 32'h5A);
        check("mr_count", 32'(count_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decrypt_data_buffer.md
DECRYPT_DATA_BUFFER -- requirements
Module: decrypt_data_buffer

Interface
REQ-001 Parameter DATA_W, default 32, input word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 4, FIFO depth in words; SHALL be a power of 2 and at least 2.
REQ-003 Parameter MSB_FIRST, default 1; 1 = most-significant byte emitted first, 0 = least-significant byte first.
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 read_ready_i  input  1  write strobe; rc4_data_i is valid this cycle.
REQ-007 rc4_data_i  input  DATA_W  word to buffer.
REQ-008 flush_i  input  1  synchronous clear of buffer contents.
REQ-009 byte_ready_i  input  1  downstream decryptor accepts byte_o this cycle.
REQ-010 byte_o  output  8  current byte lane of the head word.
REQ-011 byte_valid_o  output  1  byte_o holds valid data.
REQ-012 full_o  output  1  count_o equals DEPTH.
REQ-013 empty_o  output  1  count_o equals 0.
REQ-014 count_o  output  clog2(DEPTH)+1  number of stored words, including a partially consumed head word.
REQ-015 overflow_o  output  1  sticky flag set when a write is dropped.

Function
REQ-016 A push SHALL occur when read_ready_i=1, full_o=0 and flush_i=0; the word is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 When read_ready_i=1 and full_o=1, the word SHALL be dropped, storage SHALL be unchanged and overflow_o SHALL be set, even if a pop occurs in the same cycle.
REQ-018 byte_valid_o SHALL equal !empty_o; a word pushed at edge N SHALL present its first byte from the cycle following edge N (one-cycle latency).
REQ-019 byte_o SHALL select lane L of mem[rd_ptr]: with MSB_FIRST=1, bits [DATA_W-1-8L -: 8]; with MSB_FIRST=0, bits [8L+7 -: 8].
REQ-020 A byte transfer SHALL occur when byte_valid_o=1 and byte_ready_i=1; the lane counter L increments by 1.
REQ-021 On a transfer with L = DATA_W/8-1, the block SHALL pop: L returns to 0 and rd_ptr increments modulo DEPTH.
REQ-022 byte_o and L SHALL hold while byte_ready_i=0 or byte_valid_o=0; byte_o is don't-care while empty.
REQ-023 A simultaneous push and pop SHALL leave count_o unchanged; a push alone increments count_o by 1; a pop alone decrements it by 1.
REQ-024 flush_i=1 SHALL clear wr_ptr, rd_ptr, L, count_o and overflow_o at the next edge; flush_i overrides a push and a pop in the same cycle.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order SHALL be strictly first-in first-out.
REQ-026 overflow_o SHALL remain 1 until rst_i or flush_i is asserted.
REQ-027 full_o, empty_o and byte_valid_o SHALL be derived from registered state only, with no combinational path from read_ready_i or byte_ready_i.

Reset
REQ-028 While rst_i=1 at a rising edge, the block SHALL clear pointers, L, count_o and overflow_o; after that edge, empty_o=1, full_o=0, byte_valid_o=0 and overflow_o=0.
REQ-029 rst_i SHALL take priority over flush_i, read_ready_i and byte_ready_i; storage array contents need not be cleared.
REQ-030 Reset asserted mid-word (L != 0) SHALL discard the partial word; the first byte after reset SHALL come from the next pushed word at lane 0.

Verification
REQ-031 Defaults: push 32'hA1B2C3D4, byte_ready_i=1 -> bytes A1,B2,C3,D4 on four consecutive cycles, then empty_o=1.
REQ-032 MSB_FIRST=0: push 32'h11223344 -> bytes 44,33,22,11.
REQ-033 Fill: push 5 words with byte_ready_i=0 -> full_o=1 after the 4th push, 5th word dropped, overflow_o=1, count_o=4; draining yields only the first 4 words, in order.
REQ-034 Full plus drain: with full_o=1, push while the last lane is popped -> push dropped, count_o=3, overflow_o=1.
REQ-035 Wrap: stream 10 words 32'h00000000..32'h00000009 with random byte_ready_i -> 40 bytes out, in order, with no loss.
REQ-036 Flush on lane 2 of a word with 3 words stored, and read_ready_i=1 in the same cycle -> count_o=0, empty_o=1, overflow_o=0; the next push emits from lane 0.
